// File: rtl/acc_ram_readback_checker.sv
// -----------------------------------------------------------------------------
// acc_ram_readback_checker
//
// Purpose
//   Read-side partner of the accumulator RAM write path. Once BIST has filled
//   the RAM, a run walks pattern addresses 0..NUM_PAT-1. For each address it
//   reads the stored systolic result, compares it with the expected value from
//   the test-pattern ROM, and streams one result beat downstream. It also keeps
//   a saturating error count and the address of the first failing pattern.
//
// Ports
//   clk              in   1       system clock, all state on rising edge
//   rst              in   1       asynchronous reset, active-high
//   start            in   1       1-cycle pulse, begins a readback run
//   rd_addr          out  ADDR_W  RAM read address, also indexes the ROM
//   rd_data          in   DATA_W  RAM dout, valid 1 cycle after rd_addr
//   exp_data         in   DATA_W  ROM expected value, combinational on rd_addr
//   out_valid        out  1       result beat available
//   out_ready        in   1       downstream accepts beat
//   out_addr         out  ADDR_W  pattern address of beat
//   out_data         out  DATA_W  value read from RAM
//   out_mismatch     out  1       1 = out_data differs from expected
//   busy             out  1       run in progress
//   done             out  1       run finished, held until next start/reset
//   err_count        out  CNT_W   mismatches this run, saturating
//   fail_seen        out  1       at least one mismatch this run
//   first_fail_addr  out  ADDR_W  address of first mismatch, 0 if none
//   dbg_state        out  3       current FSM state encoding (state_t)
//
// Output handshake
//   A beat transfers on a rising edge where out_valid and out_ready are both 1.
//   out_valid is a pure function of the FSM state (never of out_ready); once
//   raised it stays high, with out_addr/out_data/out_mismatch held stable,
//   until the transfer happens, and it drops in the cycle after the transfer.
// -----------------------------------------------------------------------------
module acc_ram_readback_checker #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int NUM_PAT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] exp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_mismatch,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic              fail_seen,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CMP   = 3'd3,
        S_SEND  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PAT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   idx;
    logic [DATA_W-1:0]   exp_q;

    logic                start_run;
    logic                handshake;
    logic                last_beat;
    logic                mismatch_now;

    assign last_beat    = (idx == LAST_IDX);
    assign mismatch_now = (rd_data != exp_q);
    assign dbg_state    = state;

    // -------------------------------------------------------------------------
    // FSM next-state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        handshake = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy      = 1'b1;
                state_nxt = S_CMP;
            end
            S_CMP: begin
                busy      = 1'b1;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    handshake = 1'b1;
                    state_nxt = last_beat ? S_FIN : S_ISSUE;
                end
            end
            S_FIN: begin
                done = 1'b1;
                if (start) begin
                    start_run = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath
    // rd_addr is loaded on the edge that enters ISSUE, so the ROM output is
    // already settled for the whole ISSUE cycle and can be captured into exp_q.
    // The synchronous RAM presents rd_data from WAIT onward; rd_addr does not
    // move until the handshake, so rd_data is still valid in CMP.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx             <= '0;
            rd_addr         <= '0;
            exp_q           <= '0;
            out_addr        <= '0;
            out_data        <= '0;
            out_mismatch    <= 1'b0;
            err_count       <= '0;
            fail_seen       <= 1'b0;
            first_fail_addr <= '0;
        end else begin
            if (start_run) begin
                idx             <= '0;
                rd_addr         <= '0;
                err_count       <= '0;
                fail_seen       <= 1'b0;
                first_fail_addr <= '0;
            end

            if (state == S_ISSUE) begin
                exp_q <= exp_data;
            end

            if (state == S_CMP) begin
                out_data     <= rd_data;
                out_addr     <= idx;
                out_mismatch <= mismatch_now;
                if (mismatch_now) begin
                    if (err_count != CNT_MAX) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (!fail_seen) begin
                        fail_seen       <= 1'b1;
                        first_fail_addr <= idx;
                    end
                end
            end

            // idx stops at the last pattern; the run ends in FIN instead.
            if (handshake && !last_beat) begin
                idx     <= idx + 1'b1;
                rd_addr <= idx + 1'b1;
            end
        end
    end

endmodule
